mips_main_control: RTL and testbench

- Multi-cycle MIPS main control FSM.
- Producer side of the 3-bit ALUOP bus consumed by the ALU control decoder.
- Sequences fetch/decode/execute/memory/writeback per opcode and drives all datapath enables.
- Stalls on a memory ready handshake.

---
 rtl/mips_ctrl_pkg.sv | 38 +++
 rtl/mips_main_control_imm_aluop_decode.sv | 24 ++
 rtl/mips_main_control.sv | 148 ++++++++++++++
 tb/tb_mips_main_control.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: opcode, ALUOP, selector and state encodings shared by the main control FSM
package mips_ctrl_pkg;
    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_XORI  = 6'd14;
    localparam logic [5:0] OP_LUI   = 6'd15;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_AND   = 3'b010;
    localparam logic [2:0] ALUOP_OR    = 3'b011;
    localparam logic [2:0] ALUOP_XOR   = 3'b100;
    localparam logic [2:0] ALUOP_SLT   = 3'b101;
    localparam logic [2:0] ALUOP_LUI   = 3'b110;
    localparam logic [2:0] ALUOP_FUNCT = 3'b111;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_4    = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWR, S_MEMWB,
        S_RTYPE_EX, S_RTYPE_WB, S_BRANCH, S_JUMP, S_IMM_EX, S_IMM_WB
    } state_t;
endpackage

// File: rtl/mips_main_control_imm_aluop_decode.sv
// imm_aluop_decode: maps an immediate-class opcode to its ALUOP and extension mode
module imm_aluop_decode
    import mips_ctrl_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 3
) (
    input  logic [OP_W-1:0]    i_opcode,
    output logic [ALUOP_W-1:0] o_aluop,
    output logic               o_ext_op
);
    always_comb begin
        o_aluop  = ALUOP_ADD;
        o_ext_op = 1'b1;
        case (i_opcode)
            OP_SLTI: o_aluop = ALUOP_SLT;
            OP_ANDI: {o_aluop, o_ext_op} = {ALUOP_AND, 1'b0};
            OP_ORI:  {o_aluop, o_ext_op} = {ALUOP_OR, 1'b0};
            OP_XORI: {o_aluop, o_ext_op} = {ALUOP_XOR, 1'b0};
            OP_LUI:  {o_aluop, o_ext_op} = {ALUOP_LUI, 1'b0};
            default: ;
        endcase
    end
endmodule

// File: rtl/mips_main_control.sv
// mips_main_control: multi-cycle MIPS control FSM with memory-ready stalls and Moore datapath enables
module mips_main_control
    import mips_ctrl_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [OP_W-1:0]    Opcode,
    input  logic               Zero,
    input  logic               mem_ready,
    output logic [ALUOP_W-1:0] ALUOP,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegDst,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic               ExtOp,
    output logic [1:0]         PCSource,
    output logic               illegal_op,
    output logic               instr_done
);
    state_t               r_state, w_state_nxt;
    logic [ALUOP_W-1:0]   w_imm_aluop;
    logic                 w_imm_ext;

    imm_aluop_decode #(.OP_W(OP_W), .ALUOP_W(ALUOP_W)) u_imm_dec (
        .i_opcode (Opcode),
        .o_aluop  (w_imm_aluop),
        .o_ext_op (w_imm_ext)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = S_FETCH;
        ALUOP       = ALUOP_ADD;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_B;
        ExtOp       = 1'b0;
        PCSource    = PCSRC_ALU;
        illegal_op  = 1'b0;
        instr_done  = 1'b0;
        case (r_state)
            S_FETCH: begin
                MemRead     = 1'b1;
                ALUSrcB     = SRCB_4;
                IRWrite     = mem_ready;
                PCWrite     = mem_ready;
                w_state_nxt = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcB = SRCB_IMM2;
                case (Opcode)
                    OP_RTYPE:                    w_state_nxt = S_RTYPE_EX;
                    OP_LW, OP_SW:                w_state_nxt = S_MEMADR;
                    OP_BEQ, OP_BNE:              w_state_nxt = S_BRANCH;
                    OP_J:                        w_state_nxt = S_JUMP;
                    OP_ADDI, OP_SLTI, OP_ANDI,
                    OP_ORI, OP_XORI, OP_LUI:     w_state_nxt = S_IMM_EX;
                    default:                     illegal_op  = 1'b1;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = SRCB_IMM;
                ExtOp       = 1'b1;
                w_state_nxt = (Opcode == OP_LW) ? S_MEMRD : (Opcode == OP_SW) ? S_MEMWR : S_FETCH;
            end
            S_MEMRD: begin
                MemRead     = 1'b1;
                IorD        = 1'b1;
                w_state_nxt = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWR: begin
                MemWrite    = 1'b1;
                IorD        = 1'b1;
                instr_done  = mem_ready;
                w_state_nxt = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_MEMWB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                instr_done = 1'b1;
            end
            S_RTYPE_EX: begin
                ALUSrcA     = 1'b1;
                ALUOP       = ALUOP_FUNCT;
                w_state_nxt = S_RTYPE_WB;
            end
            S_RTYPE_WB: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOP       = ALUOP_SUB;
                PCSource    = PCSRC_ALUOUT;
                PCWriteCond = (Opcode == OP_BEQ && Zero) || (Opcode == OP_BNE && !Zero);
                instr_done  = 1'b1;
            end
            S_JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = PCSRC_JUMP;
                instr_done = 1'b1;
            end
            S_IMM_EX: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = SRCB_IMM;
                ALUOP       = w_imm_aluop;
                ExtOp       = w_imm_ext;
                w_state_nxt = S_IMM_WB;
            end
            S_IMM_WB: begin
                RegWrite   = 1'b1;
                ALUOP      = w_imm_aluop;
                ExtOp      = w_imm_ext;
                instr_done = 1'b1;
            end
            default: ;
        endcase
        // reset masks every enable in the reset cycle itself
        if (rst) begin
            {ALUOP, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
             RegWrite, ALUSrcA, ALUSrcB, ExtOp, PCSource, illegal_op, instr_done} = '0;
        end
    end
endmodule

// File: tb/tb_mips_main_control.sv
// tb_mips_main_control: instruction-level model expands each opcode into per-cycle expected controls
module tb_mips_main_control;
    typedef struct packed {
        logic [2:0] aluop;
        logic       pcw, pcwc, iord, mr, mw, irw, rdst, m2r, rw, asa;
        logic [1:0] asb;
        logic       ext;
        logic [1:0] pcs;
        logic       ill, done;
    } out_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] Opcode = '0;
    logic       Zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic [2:0] ALUOP;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg;
    logic       RegWrite, ALUSrcA, ExtOp, illegal_op, instr_done;
    logic [1:0] ALUSrcB, PCSource;

    out_t  dut_o, exp_o;
    logic  vld = 1'b0;
    int    checks = 0, errors = 0, cyc = 0;
    int    n_rw = 0, n_pcwc = 0, n_ill = 0, n_done = 0, n_mrio = 0;
    logic  ended;
    string tag = "reset";

    always #5 clk = ~clk;

    mips_main_control dut (
        .clk(clk), .rst(rst), .Opcode(Opcode), .Zero(Zero), .mem_ready(mem_ready),
        .ALUOP(ALUOP), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ExtOp(ExtOp), .PCSource(PCSource), .illegal_op(illegal_op), .instr_done(instr_done)
    );

    assign dut_o = {ALUOP, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegDst,
                    MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ExtOp, PCSource, illegal_op, instr_done};

    always @(negedge clk) begin
        if (vld) begin
            checks++;
            if (dut_o !== exp_o) begin
                errors++;
                $display("FAIL %s cycle %0d: got %b want %b", tag, cyc, dut_o, exp_o);
            end
        end
    end

    task automatic chk(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, want);
        end
    endtask

    // Which instruction class an opcode belongs to: 0 R, 1 lw, 2 sw, 3 branch, 4 jump, 5 imm, 6 illegal
    function automatic int kind(input logic [5:0] op);
        if (op == 0) return 0;
        if (op == 35) return 1;
        if (op == 43) return 2;
        if (op == 4 || op == 5) return 3;
        if (op == 2) return 4;
        if (op == 8 || op == 10 || (op >= 12 && op <= 15)) return 5;
        return 6;
    endfunction

    // {ALUOP, ExtOp} for the immediate group, straight from the instruction table
    function automatic logic [3:0] imm_row(input logic [5:0] op);
        logic [3:0] tab [16];
        tab = '{default: 4'b0000};
        tab[8] = 4'b000_1; tab[10] = 4'b101_1; tab[12] = 4'b010_0;
        tab[13] = 4'b011_0; tab[14] = 4'b100_0; tab[15] = 4'b110_0;
        return tab[op[3:0]];
    endfunction

    function automatic out_t e_fetch(input logic rdy);
        out_t o = '0;
        o.mr = 1; o.asb = 2'b01; o.irw = rdy; o.pcw = rdy;
        return o;
    endfunction

    function automatic out_t e_phase(input logic [5:0] op, input int ph, input logic z, input logic rdy);
        out_t o = '0;
        int   k = kind(op);
        if (ph == 0) begin
            o.asb = 2'b11; o.ill = (k == 6);
        end else if (k == 0) begin
            if (ph == 1) begin o.asa = 1; o.aluop = 3'b111; end
            else begin o.rw = 1; o.rdst = 1; o.done = 1; end
        end else if (k == 1 || k == 2) begin
            if (ph == 1) begin o.asa = 1; o.asb = 2'b10; o.ext = 1; end
            else if (ph == 2) begin
                o.iord = 1; o.mr = (k == 1); o.mw = (k == 2); o.done = (k == 2) && rdy;
            end else begin o.rw = 1; o.m2r = 1; o.done = 1; end
        end else if (k == 3) begin
            o.asa = 1; o.aluop = 3'b001; o.pcs = 2'b01; o.done = 1;
            o.pcwc = (op == 4) ? z : !z;
        end else if (k == 4) begin
            o.pcw = 1; o.pcs = 2'b10; o.done = 1;
        end else begin
            {o.aluop, o.ext} = imm_row(op);
            if (ph == 1) begin o.asa = 1; o.asb = 2'b10; end
            else begin o.rw = 1; o.done = 1; end
        end
        return o;
    endfunction

    task automatic step(input logic r, input logic [5:0] op, input logic z, input logic rdy, input out_t e);
        @(posedge clk);
        #1;
        rst = r; Opcode = op; Zero = z; mem_ready = rdy;
        exp_o = e; vld = 1'b1; cyc++;
        @(negedge clk);
        #1;
        ended = instr_done | illegal_op;
        n_rw += int'(RegWrite); n_pcwc += int'(PCWriteCond); n_ill += int'(illegal_op);
        n_done += int'(instr_done); n_mrio += int'(MemRead & IorD);
    endtask

    // Run one instruction with given FETCH and memory-phase stalls; check latency measured from the DUT
    task automatic instr(input string name, input logic [5:0] op, input logic z,
                         input int fst, input int mst, input int lat);
        int k = kind(op), n = 0, got = -1, d0 = n_done;
        tag = name;
        for (int i = 0; i < fst; i++) begin step(0, op, z, 0, e_fetch(0)); n++; if (ended && got < 0) got = n; end
        step(0, op, z, 1, e_fetch(1)); n++; if (ended && got < 0) got = n;
        step(0, op, z, 1, e_phase(op, 0, z, 1)); n++; if (ended && got < 0) got = n;
        if (k == 0 || k == 5) begin
            for (int p = 1; p <= 2; p++) begin step(0, op, z, 1, e_phase(op, p, z, 1)); n++; if (ended && got < 0) got = n; end
        end else if (k == 1 || k == 2) begin
            step(0, op, z, 1, e_phase(op, 1, z, 1)); n++; if (ended && got < 0) got = n;
            for (int i = 0; i < mst; i++) begin step(0, op, z, 0, e_phase(op, 2, z, 0)); n++; if (ended && got < 0) got = n; end
            step(0, op, z, 1, e_phase(op, 2, z, 1)); n++; if (ended && got < 0) got = n;
            if (k == 1) begin step(0, op, z, 1, e_phase(op, 3, z, 1)); n++; if (ended && got < 0) got = n; end
        end else if (k == 3 || k == 4) begin
            step(0, op, z, 1, e_phase(op, 1, z, 1)); n++; if (ended && got < 0) got = n;
        end
        chk({name, " latency"}, got, lat);
        chk({name, " done pulses"}, n_done - d0, (k == 6) ? 0 : 1);
    endtask

    initial begin
        int rw0, pc0, il0, mr0;
        step(1, 0, 0, 0, '0);
        step(1, 0, 0, 1, '0);

        instr("rtype", 6'd0, 0, 0, 0, 4);

        rw0 = n_rw; mr0 = n_mrio;
        instr("lw_stall2", 6'd35, 0, 0, 2, 7);
        chk("lw regwrite count", n_rw - rw0, 1);
        chk("lw memread/iord cycles", n_mrio - mr0, 3);
        instr("lw", 6'd35, 0, 0, 0, 5);
        instr("sw", 6'd43, 0, 0, 0, 4);
        instr("sw_stall1", 6'd43, 0, 0, 1, 5);

        pc0 = n_pcwc;
        instr("beq_z1", 6'd4, 1, 0, 0, 3);
        chk("beq_z1 pcwritecond", n_pcwc - pc0, 1);
        pc0 = n_pcwc;
        instr("beq_z0", 6'd4, 0, 0, 0, 3);
        chk("beq_z0 pcwritecond", n_pcwc - pc0, 0);
        pc0 = n_pcwc;
        instr("bne_z1", 6'd5, 1, 0, 0, 3);
        chk("bne_z1 pcwritecond", n_pcwc - pc0, 0);
        pc0 = n_pcwc;
        instr("bne_z0", 6'd5, 0, 0, 0, 3);
        chk("bne_z0 pcwritecond", n_pcwc - pc0, 1);
        instr("jump", 6'd2, 0, 0, 0, 3);

        instr("addi", 6'd8, 0, 0, 0, 4);
        instr("slti", 6'd10, 0, 0, 0, 4);
        instr("andi", 6'd12, 0, 0, 0, 4);
        instr("ori", 6'd13, 0, 0, 0, 4);
        instr("xori", 6'd14, 0, 0, 0, 4);
        instr("lui", 6'd15, 0, 0, 0, 4);

        il0 = n_ill; rw0 = n_rw;
        instr("illegal63", 6'd63, 0, 0, 0, 2);
        instr("illegal9", 6'd9, 0, 0, 0, 2);
        chk("illegal pulses", n_ill - il0, 2);
        chk("illegal regwrite", n_rw - rw0, 0);
        instr("after_illegal", 6'd0, 0, 0, 0, 4);
        instr("rtype_fstall2", 6'd0, 0, 2, 0, 6);

        tag = "rst_in_fetch_stall";
        step(0, 6'd2, 0, 0, e_fetch(0));
        step(0, 6'd2, 0, 0, e_fetch(0));
        step(1, 6'd2, 0, 0, '0);
        instr("jump_after_rst", 6'd2, 0, 1, 0, 4);

        tag = "rst_in_memrd_stall";
        step(0, 6'd35, 0, 1, e_fetch(1));
        step(0, 6'd35, 0, 1, e_phase(6'd35, 0, 0, 1));
        step(0, 6'd35, 0, 1, e_phase(6'd35, 1, 0, 1));
        step(0, 6'd35, 0, 0, e_phase(6'd35, 2, 0, 0));
        step(1, 6'd35, 0, 0, '0);
        instr("lw_after_rst", 6'd35, 0, 0, 0, 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
